uart_tx_serializer: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_serializer.sv | 131 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity modes and the parity helper
// used by both the TX and RX paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  // Widest data word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int PARITY_MAX_WIDTH = 16;

  function automatic logic calc_parity(input logic [PARITY_MAX_WIDTH-1:0] data,
                                       input logic [1:0] mode);
    case (mode)
      PARITY_ODD:  calc_parity = ~^data;
      PARITY_EVEN: calc_parity = ^data;
      default:     calc_parity = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from a show-ahead FIFO and shifts them out as
// start / data (LSB first) / optional parity / stop bits, back-to-back while data remains.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1085,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  uart_tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic [1:0]    MODE      = 2'(PARITY_MODE);

  tx_state_t             state, state_n;
  logic [CW-1:0]         bit_cnt, bit_cnt_n;
  logic [IW-1:0]         data_idx, data_idx_n;
  logic                  stop_idx, stop_idx_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic                  parity, parity_n;
  logic                  tx_n, busy_n, done_n;
  logic                  bit_end, frame_end, pop;
  logic [PARITY_MAX_WIDTH-1:0] rd_wide;

  // Handshake: fifo_rd_data is valid whenever !fifo_empty; fifo_rd_en acts as ready,
  // and the byte transfers on any clock edge where both are high.
  assign bit_end    = (bit_cnt == BIT_LAST);
  assign frame_end  = (state == STOP) && (stop_idx == STOP_LAST) && bit_end;
  assign pop        = tx_enable && !fifo_empty && ((state == IDLE) || frame_end);
  assign fifo_rd_en = pop;

  always_comb begin
    rd_wide = '0;
    rd_wide[DATA_WIDTH-1:0] = fifo_rd_data;
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_end ? '0 : bit_cnt + CW'(1);
    data_idx_n = data_idx;
    stop_idx_n = stop_idx;
    shift_n    = shift;
    parity_n   = parity;
    tx_n       = 1'b1;

    case (state)
      IDLE:  bit_cnt_n = '0;
      START: if (bit_end) begin
        state_n    = DATA;
        data_idx_n = '0;
      end
      DATA: if (bit_end) begin
        shift_n = shift >> 1;
        if (data_idx == IDX_LAST) begin
          state_n    = (MODE == PARITY_NONE) ? STOP : PARITY;
          stop_idx_n = 1'b0;
        end else begin
          data_idx_n = data_idx + IW'(1);
        end
      end
      PARITY: if (bit_end) begin
        state_n    = STOP;
        stop_idx_n = 1'b0;
      end
      STOP: if (bit_end) begin
        if (stop_idx == STOP_LAST) state_n = IDLE;
        else                       stop_idx_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // A pop overrides the end-of-frame return to IDLE, giving gapless frames.
    if (pop) begin
      state_n    = START;
      bit_cnt_n  = '0;
      data_idx_n = '0;
      stop_idx_n = 1'b0;
      shift_n    = fifo_rd_data;
      parity_n   = calc_parity(rd_wide, MODE);
    end

    // Line outputs are registered from the next state so they change with it.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = parity_n;
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == STOP) && (stop_idx_n == STOP_LAST) && (bit_cnt_n == BIT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      data_idx <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      parity   <= 1'b0;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      data_idx <= data_idx_n;
      stop_idx <= stop_idx_n;
      shift    <= shift_n;
      parity   <= parity_n;
      uart_tx  <= tx_n;
      tx_busy  <= busy_n;
      tx_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four instances (8N1, 8E1, 8O1, 8N2) at four
// clocks per bit, each fed by a small bench-side show-ahead FIFO model.
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_enable;
  logic [3:0] fifo_empty, fifo_rd_en, uart_tx, tx_busy, tx_done;
  logic [7:0] fifo_rd_data [0:3];

  logic [7:0] fmem [0:3][0:3];
  int         fcnt [0:3];

  logic cap_tx [0:99];
  logic cap_busy [0:99];
  logic cap_done [0:99];
  logic cap_rd [0:99];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_empty(fifo_empty[0]),
    .fifo_rd_data(fifo_rd_data[0]), .fifo_rd_en(fifo_rd_en[0]), .uart_tx(uart_tx[0]),
    .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_empty(fifo_empty[1]),
    .fifo_rd_data(fifo_rd_data[1]), .fifo_rd_en(fifo_rd_en[1]), .uart_tx(uart_tx[1]),
    .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_empty(fifo_empty[2]),
    .fifo_rd_data(fifo_rd_data[2]), .fifo_rd_en(fifo_rd_en[2]), .uart_tx(uart_tx[2]),
    .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_empty(fifo_empty[3]),
    .fifo_rd_data(fifo_rd_data[3]), .fifo_rd_en(fifo_rd_en[3]), .uart_tx(uart_tx[3]),
    .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

  task automatic refresh(input int i);
    fifo_empty[i]   = (fcnt[i] == 0);
    fifo_rd_data[i] = fmem[i][0];
  endtask

  task automatic push(input int i, input logic [7:0] b);
    fmem[i][fcnt[i]] = b;
    fcnt[i]++;
    refresh(i);
  endtask

  // Records one DUT's outputs for cycles start..start+n-1 and pops the FIFO model
  // on every edge where fifo_rd_en was high. Entered and left at posedge + 1.
  task automatic capture(input int i, input int start, input int n);
    logic popped;
    for (int k = start; k < start + n; k++) begin
      #1;
      cap_tx[k]   = uart_tx[i];
      cap_busy[k] = tx_busy[i];
      cap_done[k] = tx_done[i];
      cap_rd[k]   = fifo_rd_en[i];
      popped      = fifo_rd_en[i];
      @(posedge clk);
      #1;
      if (popped) begin
        for (int j = 0; j < 3; j++) fmem[i][j] = fmem[i][j+1];
        fcnt[i]--;
        refresh(i);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({uart_tx, tx_busy, tx_done, fifo_rd_en} !== {4'hF, 4'h0, 4'h0, 4'h0}) begin
      tests_failed++;
      $display("FAIL reset_async: tx/busy/done/rd got %h%h%h%h want f000",
               uart_tx, tx_busy, tx_done, fifo_rd_en);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({uart_tx, tx_busy, tx_done} !== {4'hF, 4'h0, 4'h0}) begin
      tests_failed++;
      $display("FAIL reset_held: tx/busy/done got %h%h%h want f00", uart_tx, tx_busy, tx_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [9:0] bits = 10'b1101001010;
    logic [2:0] exp;
    int pops = 0;
    push(0, 8'hA5);
    capture(0, 0, 42);
    for (int k = 0; k < 42; k++) pops += int'(cap_rd[k]);
    tests_run++;
    if (pops != 1 || cap_rd[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_pop: got %0d pops (cycle0=%b) want 1 at cycle 0", pops, cap_rd[0]);
    end
    for (int k = 1; k <= 41; k++) begin
      exp = (k <= 40) ? {bits[(k-1)/CPB], 1'b1, k == 40} : 3'b100;
      tests_run++;
      if ({cap_tx[k], cap_busy[k], cap_done[k]} !== exp) begin
        tests_failed++;
        $display("FAIL single[%0d]: tx/busy/done got %b%b%b want %b",
                 k, cap_tx[k], cap_busy[k], cap_done[k], exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits0 = 10'b1000000000;
    logic [9:0] bits1 = 10'b1111111110;
    logic [2:0] exp;
    logic       b;
    push(0, 8'h00);
    push(0, 8'hFF);
    capture(0, 0, 82);
    for (int k = 0; k < 82; k++) begin
      tests_run++;
      if (cap_rd[k] !== (k == 0 || k == 40)) begin
        tests_failed++;
        $display("FAIL b2b_rd[%0d]: got %b want %b", k, cap_rd[k], (k == 0 || k == 40));
      end
    end
    for (int k = 1; k <= 81; k++) begin
      b = (k <= 40) ? bits0[(k-1)/CPB] : bits1[(k-41)/CPB];
      exp = (k <= 80) ? {b, 1'b1, (k == 40 || k == 80)} : 3'b100;
      tests_run++;
      if ({cap_tx[k], cap_busy[k], cap_done[k]} !== exp) begin
        tests_failed++;
        $display("FAIL b2b[%0d]: tx/busy/done got %b%b%b want %b",
                 k, cap_tx[k], cap_busy[k], cap_done[k], exp);
      end
    end
  endtask

  task automatic test_parity();
    logic [10:0] bits_even = 11'b11000001110;
    logic [10:0] bits_odd  = 11'b10000001110;
    logic [2:0]  exp;
    push(1, 8'h07);
    capture(1, 0, 46);
    for (int k = 1; k <= 45; k++) begin
      exp = (k <= 44) ? {bits_even[(k-1)/CPB], 1'b1, k == 44} : 3'b100;
      tests_run++;
      if ({cap_tx[k], cap_busy[k], cap_done[k]} !== exp) begin
        tests_failed++;
        $display("FAIL even[%0d]: tx/busy/done got %b%b%b want %b",
                 k, cap_tx[k], cap_busy[k], cap_done[k], exp);
      end
    end
    push(2, 8'h07);
    capture(2, 0, 46);
    for (int k = 1; k <= 45; k++) begin
      exp = (k <= 44) ? {bits_odd[(k-1)/CPB], 1'b1, k == 44} : 3'b100;
      tests_run++;
      if ({cap_tx[k], cap_busy[k], cap_done[k]} !== exp) begin
        tests_failed++;
        $display("FAIL odd[%0d]: tx/busy/done got %b%b%b want %b",
                 k, cap_tx[k], cap_busy[k], cap_done[k], exp);
      end
    end
  endtask

  task automatic test_no_data();
    capture(0, 0, 20);
    for (int k = 0; k < 20; k++) begin
      tests_run++;
      if ({cap_rd[k], cap_tx[k], cap_busy[k]} !== 3'b010) begin
        tests_failed++;
        $display("FAIL empty[%0d]: rd/tx/busy got %b%b%b want 010",
                 k, cap_rd[k], cap_tx[k], cap_busy[k]);
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [9:0] bits_c3 = 10'b1110000110;
    logic [9:0] bits_33 = 10'b1001100110;
    logic [2:0] exp;
    int pops = 0;
    push(0, 8'hC3);
    push(0, 8'h33);
    capture(0, 0, 10);
    tx_enable = 1'b0;
    capture(0, 10, 50);
    for (int k = 0; k < 60; k++) pops += int'(cap_rd[k]);
    tests_run++;
    if (pops != 1 || fcnt[0] != 1) begin
      tests_failed++;
      $display("FAIL endrop_pops: got %0d pops, %0d left want 1 pop, 1 left", pops, fcnt[0]);
    end
    for (int k = 1; k < 60; k++) begin
      exp = (k <= 40) ? {bits_c3[(k-1)/CPB], 1'b1, k == 40} : 3'b100;
      tests_run++;
      if ({cap_tx[k], cap_busy[k], cap_done[k]} !== exp) begin
        tests_failed++;
        $display("FAIL endrop[%0d]: tx/busy/done got %b%b%b want %b",
                 k, cap_tx[k], cap_busy[k], cap_done[k], exp);
      end
    end
    tx_enable = 1'b1;
    capture(0, 0, 42);
    tests_run++;
    if (cap_rd[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL reenable_pop: got %b want 1", cap_rd[0]);
    end
    for (int k = 1; k <= 41; k++) begin
      exp = (k <= 40) ? {bits_33[(k-1)/CPB], 1'b1, k == 40} : 3'b100;
      tests_run++;
      if ({cap_tx[k], cap_busy[k], cap_done[k]} !== exp) begin
        tests_failed++;
        $display("FAIL reenable[%0d]: tx/busy/done got %b%b%b want %b",
                 k, cap_tx[k], cap_busy[k], cap_done[k], exp);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits_3c = 10'b1001111000;
    logic [2:0] exp;
    push(0, 8'h5A);
    push(0, 8'h3C);
    capture(0, 0, 18);
    tests_run++;
    if ({cap_tx[14], cap_busy[17]} !== 2'b01) begin
      tests_failed++;
      $display("FAIL midrst_pre: bit2/busy got %b%b want 01", cap_tx[14], cap_busy[17]);
    end
    #2;
    rst_n     = 1'b0;
    tx_enable = 1'b0;
    #1;
    tests_run++;
    if ({uart_tx[0], tx_busy[0], tx_done[0]} !== 3'b100) begin
      tests_failed++;
      $display("FAIL midrst_async: tx/busy/done got %b%b%b want 100",
               uart_tx[0], tx_busy[0], tx_done[0]);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({uart_tx[0], tx_busy[0], fcnt[0]} !== {2'b10, 32'd1}) begin
      tests_failed++;
      $display("FAIL midrst_idle: tx/busy got %b%b fifo %0d want 10 fifo 1",
               uart_tx[0], tx_busy[0], fcnt[0]);
    end
    tx_enable = 1'b1;
    capture(0, 0, 42);
    tests_run++;
    if (cap_rd[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_pop: got %b want 1", cap_rd[0]);
    end
    for (int k = 1; k <= 41; k++) begin
      exp = (k <= 40) ? {bits_3c[(k-1)/CPB], 1'b1, k == 40} : 3'b100;
      tests_run++;
      if ({cap_tx[k], cap_busy[k], cap_done[k]} !== exp) begin
        tests_failed++;
        $display("FAIL midrst[%0d]: tx/busy/done got %b%b%b want %b",
                 k, cap_tx[k], cap_busy[k], cap_done[k], exp);
      end
    end
  endtask

  task automatic test_two_stop();
    logic [10:0] bits = 11'b11100000010;
    logic [2:0]  exp;
    push(3, 8'h81);
    capture(3, 0, 46);
    for (int k = 1; k <= 45; k++) begin
      exp = (k <= 44) ? {bits[(k-1)/CPB], 1'b1, k == 44} : 3'b100;
      tests_run++;
      if ({cap_tx[k], cap_busy[k], cap_done[k]} !== exp) begin
        tests_failed++;
        $display("FAIL stop2[%0d]: tx/busy/done got %b%b%b want %b",
                 k, cap_tx[k], cap_busy[k], cap_done[k], exp);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b1;
    tx_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fcnt[i] = 0;
      for (int j = 0; j < 4; j++) fmem[i][j] = 8'h00;
      refresh(i);
    end
    #1;
    rst_n = 1'b0;
    test_reset();
    tx_enable = 1'b1;
    test_single_frame();
    test_back_to_back();
    test_parity();
    test_no_data();
    test_enable_drop();
    test_reset_mid_frame();
    test_two_stop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
